// File: rtl/pipeline_trace_gen_pkg.sv
// rtl/pipeline_trace_gen_pkg.sv - shared slot/record types and tag helpers for the trace generator
package pipeline_trace_gen_pkg;
   localparam int TAG_W   = 7;
   localparam int PC_W    = 16;
   localparam int INSTR_W = 16;

   typedef struct packed {
      logic               valid;
      logic [TAG_W-1:0]   tag;
      logic [PC_W-1:0]    pc;
      logic [INSTR_W-1:0] instr;
   } slot_t;

   typedef struct packed {
      logic [TAG_W-1:0]   tag;
      logic [PC_W-1:0]    pc;
      logic [INSTR_W-1:0] instr;
   } retire_rec_t;

   localparam int REC_W = $bits(retire_rec_t);

   function automatic logic [TAG_W-1:0] tag_inc(input logic [TAG_W-1:0] t,
                                                input logic [TAG_W-1:0] tmax);
      return (t == tmax) ? '0 : t + 1'b1;
   endfunction
endpackage

// File: rtl/pipeline_trace_gen_if.sv
// rtl/pipeline_trace_gen_if.sv - fetch/control inputs and retire stream of the trace generator
interface pipeline_trace_gen_if;
   import pipeline_trace_gen_pkg::*;

   logic               stall;
   logic               flush;
   logic               fetch_valid;
   logic [PC_W-1:0]    fetch_pc;
   logic [INSTR_W-1:0] fetch_instr;
   logic               retire_valid;
   logic               retire_ready;
   logic [TAG_W-1:0]   retire_tag;
   logic [PC_W-1:0]    retire_pc;
   logic [INSTR_W-1:0] retire_instr;

   modport master (
      output stall, flush, fetch_valid, fetch_pc, fetch_instr, retire_ready,
      input  retire_valid, retire_tag, retire_pc, retire_instr
   );

   modport slave (
      input  stall, flush, fetch_valid, fetch_pc, fetch_instr, retire_ready,
      output retire_valid, retire_tag, retire_pc, retire_instr
   );
endinterface

// File: rtl/pipeline_trace_gen_trace_fifo.sv
// rtl/pipeline_trace_gen_trace_fifo.sv - retire-record FIFO; head read straight from registered storage
module trace_fifo #(
   parameter int WIDTH = 39,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_tdata,
   input  logic             in_tvalid,
   output logic [WIDTH-1:0] out_tdata,
   output logic             out_tvalid,
   input  logic             out_tready,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wptr;
   logic [AW:0]      rptr;
   logic             do_push;
   logic             do_pop;

   // Extra pointer MSB tells full from empty when the index bits match.
   assign empty      = (wptr == rptr);
   assign full       = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign out_tvalid = !empty;
   assign do_pop     = out_tvalid && out_tready;
   assign do_push    = in_tvalid && (!full || do_pop);
   assign out_tdata  = mem[rptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr[AW-1:0]] <= in_tdata;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
      end
   end
endmodule

// File: rtl/pipeline_trace_gen.sv
// rtl/pipeline_trace_gen.sv - five-slot pipeline shadow that tags fetches and queues retire records
module pipeline_trace_gen
   import pipeline_trace_gen_pkg::*;
#(
   parameter int TAG_MAX    = 71,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   pipeline_trace_gen_if.slave  bus,
   output logic                 overflow,
   output logic [7:0]           drop_cnt
);
   localparam logic [TAG_W-1:0] TAG_LAST = TAG_MAX[TAG_W-1:0];

   slot_t            if_s, id_s, ex_s, mem_s, wb_s;
   logic [TAG_W-1:0] next_tag;
   retire_rec_t      push_rec;
   retire_rec_t      head_rec;
   logic [REC_W-1:0] fifo_data;
   logic             fifo_valid;
   logic             fifo_full;
   logic             fifo_empty;
   logic             drop;

   // MEM and WB always advance; a stall freezes IF/ID and feeds a bubble to EX.
   always_ff @(posedge clk) begin
      if (rst) begin
         if_s     <= '0;
         id_s     <= '0;
         ex_s     <= '0;
         mem_s    <= '0;
         wb_s     <= '0;
         next_tag <= '0;
      end else begin
         mem_s <= ex_s;
         wb_s  <= mem_s;
         if (bus.stall) begin
            ex_s <= '0;
         end else begin
            if_s <= '{valid: bus.fetch_valid, tag: next_tag,
                      pc: bus.fetch_pc, instr: bus.fetch_instr};
            id_s <= bus.flush ? '0 : if_s;
            ex_s <= id_s;
            if (bus.fetch_valid) next_tag <= tag_inc(next_tag, TAG_LAST);
         end
      end
   end

   assign push_rec = '{tag: wb_s.tag, pc: wb_s.pc, instr: wb_s.instr};

   trace_fifo #(
      .WIDTH (REC_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .in_tdata   (push_rec),
      .in_tvalid  (wb_s.valid),
      .out_tdata  (fifo_data),
      .out_tvalid (fifo_valid),
      .out_tready (bus.retire_ready),
      .full       (fifo_full),
      .empty      (fifo_empty)
   );

   // Stale storage is never exposed: an empty queue presents an all-zero record.
   assign head_rec         = fifo_empty ? '0 : retire_rec_t'(fifo_data);
   assign bus.retire_valid = fifo_valid;
   assign bus.retire_tag   = head_rec.tag;
   assign bus.retire_pc    = head_rec.pc;
   assign bus.retire_instr = head_rec.instr;

   assign drop = wb_s.valid && fifo_full && !(fifo_valid && bus.retire_ready);

   always_ff @(posedge clk) begin
      if (rst) begin
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else if (drop) begin
         overflow <= 1'b1;
         if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_pipeline_trace_gen.sv
// tb/tb_pipeline_trace_gen.sv - directed scenario bench for pipeline_trace_gen
module tb_pipeline_trace_gen;
   logic       clk = 1'b0;
   logic       rst;
   logic       overflow;
   logic [7:0] drop_cnt;
   int         n_cmp = 0;
   int         n_bad = 0;
   int         cyc = 0;

   logic [6:0]  log_tag [$];
   logic [15:0] log_pc  [$];
   int          log_cyc [$];

   pipeline_trace_gen_if ifc();

   pipeline_trace_gen #(.TAG_MAX(71), .FIFO_DEPTH(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (ifc),
      .overflow (overflow),
      .drop_cnt (drop_cnt)
   );

   always #5 clk = ~clk;

   // Record every accepted retire with the edge number it happened on.
   always @(posedge clk) begin
      if (!rst && ifc.retire_valid && ifc.retire_ready) begin
         log_tag.push_back(ifc.retire_tag);
         log_pc.push_back(ifc.retire_pc);
         log_cyc.push_back(cyc);
      end
      cyc = cyc + 1;
   end

   task automatic cycle(input logic fv, input logic [15:0] pc, input logic [15:0] ins,
                        input logic st, input logic fl, input logic rdy);
      ifc.fetch_valid  = fv;
      ifc.fetch_pc     = pc;
      ifc.fetch_instr  = ins;
      ifc.stall        = st;
      ifc.flush        = fl;
      ifc.retire_ready = rdy;
      @(negedge clk);
   endtask

   task automatic idle(input int n, input logic rdy);
      for (int i = 0; i < n; i++) cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, rdy);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle(2, 1'b0);
      rst = 1'b0;
      log_tag.delete();
      log_pc.delete();
      log_cyc.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle(2, 1'b0);
      n_cmp++; if (ifc.retire_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %0b want 0", ifc.retire_valid); end
      n_cmp++; if (ifc.retire_tag !== 7'd0) begin n_bad++; $display("FAIL reset_tag got %0d want 0", ifc.retire_tag); end
      n_cmp++; if (ifc.retire_pc !== 16'h0) begin n_bad++; $display("FAIL reset_pc got %h want 0000", ifc.retire_pc); end
      n_cmp++; if (ifc.retire_instr !== 16'h0) begin n_bad++; $display("FAIL reset_instr got %h want 0000", ifc.retire_instr); end
      n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow got %0b want 0", overflow); end
      n_cmp++; if (drop_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_drop_cnt got %0d want 0", drop_cnt); end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      int first_seen = -1;
      do_reset();
      for (int k = 0; k < 14; k++) begin
         if (k < 6) cycle(1'b1, 16'(2 * k), 16'(16'h1000 + k), 1'b0, 1'b0, 1'b1);
         else       cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
         if (first_seen < 0 && ifc.retire_valid === 1'b1) first_seen = k + 1;
      end
      // Driven at cycle 0, captured into IF at the next edge, visible 5 cycles after that.
      n_cmp++; if (first_seen != 6) begin n_bad++; $display("FAIL basic_latency got %0d want 6", first_seen); end
      n_cmp++; if (log_tag.size() != 6) begin n_bad++; $display("FAIL basic_count got %0d want 6", log_tag.size()); end
      for (int i = 0; i < 6 && i < log_tag.size(); i++) begin
         n_cmp++; if (log_tag[i] !== 7'(i)) begin n_bad++; $display("FAIL basic_tag[%0d] got %0d want %0d", i, log_tag[i], i); end
         n_cmp++; if (log_pc[i] !== 16'(2 * i)) begin n_bad++; $display("FAIL basic_pc[%0d] got %h want %h", i, log_pc[i], 16'(2 * i)); end
      end
      if (log_cyc.size() == 6) begin
         n_cmp++; if (log_cyc[5] - log_cyc[0] != 5) begin n_bad++; $display("FAIL basic_back_to_back got %0d want 5", log_cyc[5] - log_cyc[0]); end
      end
   endtask

   task automatic test_stall();
      do_reset();
      for (int k = 0; k < 4; k++) cycle(1'b1, 16'(16'h0100 + 2 * k), 16'(16'h2000 + k), 1'b0, 1'b0, 1'b1);
      cycle(1'b1, 16'h0108, 16'h2004, 1'b1, 1'b0, 1'b1);
      cycle(1'b1, 16'h0108, 16'h2004, 1'b0, 1'b0, 1'b1);
      cycle(1'b1, 16'h010A, 16'h2005, 1'b0, 1'b0, 1'b1);
      idle(10, 1'b1);
      n_cmp++; if (log_tag.size() != 6) begin n_bad++; $display("FAIL stall_count got %0d want 6", log_tag.size()); end
      for (int i = 0; i < 6 && i < log_tag.size(); i++) begin
         n_cmp++; if (log_tag[i] !== 7'(i)) begin n_bad++; $display("FAIL stall_tag[%0d] got %0d want %0d", i, log_tag[i], i); end
      end
      if (log_cyc.size() == 6) begin
         n_cmp++; if (log_cyc[1] - log_cyc[0] != 1) begin n_bad++; $display("FAIL stall_gap01 got %0d want 1", log_cyc[1] - log_cyc[0]); end
         n_cmp++; if (log_cyc[2] - log_cyc[1] != 2) begin n_bad++; $display("FAIL stall_gap12 got %0d want 2", log_cyc[2] - log_cyc[1]); end
         n_cmp++; if (log_cyc[3] - log_cyc[2] != 1) begin n_bad++; $display("FAIL stall_gap23 got %0d want 1", log_cyc[3] - log_cyc[2]); end
         n_cmp++; if (log_pc[4] !== 16'h0108) begin n_bad++; $display("FAIL stall_pc4 got %h want 0108", log_pc[4]); end
      end
   endtask

   task automatic test_flush();
      logic [6:0] exp_t [6];
      exp_t = '{7'd0, 7'd1, 7'd2, 7'd3, 7'd5, 7'd6};
      do_reset();
      // Tag 4 is fetched at k=4 and sits in IF while k=5 is driven.
      for (int k = 0; k < 7; k++) cycle(1'b1, 16'(16'h0300 + 2 * k), 16'(16'h3000 + k), 1'b0, k == 5, 1'b1);
      idle(10, 1'b1);
      n_cmp++; if (log_tag.size() != 6) begin n_bad++; $display("FAIL flush_count got %0d want 6", log_tag.size()); end
      for (int i = 0; i < 6 && i < log_tag.size(); i++) begin
         n_cmp++; if (log_tag[i] !== exp_t[i]) begin n_bad++; $display("FAIL flush_tag[%0d] got %0d want %0d", i, log_tag[i], exp_t[i]); end
      end
      if (log_pc.size() == 6) begin
         n_cmp++; if (log_pc[4] !== 16'h030A) begin n_bad++; $display("FAIL flush_pc_tag5 got %h want 030a", log_pc[4]); end
      end
   endtask

   task automatic test_wrap();
      do_reset();
      for (int k = 0; k < 80; k++) cycle(1'b1, 16'(2 * k), 16'(k), 1'b0, 1'b0, 1'b1);
      idle(10, 1'b1);
      n_cmp++; if (log_tag.size() != 80) begin n_bad++; $display("FAIL wrap_count got %0d want 80", log_tag.size()); end
      for (int i = 0; i < 80 && i < log_tag.size(); i++) begin
         n_cmp++; if (log_tag[i] !== 7'(i % 72)) begin n_bad++; $display("FAIL wrap_tag[%0d] got %0d want %0d", i, log_tag[i], i % 72); end
      end
   endtask

   task automatic test_overflow();
      logic [6:0] exp_t [5];
      exp_t = '{7'd0, 7'd1, 7'd2, 7'd3, 7'd8};
      do_reset();
      for (int k = 0; k < 8; k++) cycle(1'b1, 16'(16'h0400 + 2 * k), 16'(16'h4000 + k), 1'b0, 1'b0, 1'b0);
      idle(8, 1'b0);
      n_cmp++; if (ifc.retire_valid !== 1'b1) begin n_bad++; $display("FAIL ovf_valid got %0b want 1", ifc.retire_valid); end
      n_cmp++; if (ifc.retire_tag !== 7'd0) begin n_bad++; $display("FAIL ovf_head_tag got %0d want 0", ifc.retire_tag); end
      n_cmp++; if (ifc.retire_pc !== 16'h0400) begin n_bad++; $display("FAIL ovf_head_pc got %h want 0400", ifc.retire_pc); end
      n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag got %0b want 1", overflow); end
      n_cmp++; if (drop_cnt !== 8'd4) begin n_bad++; $display("FAIL ovf_drop_cnt got %0d want 4", drop_cnt); end
      idle(2, 1'b0);
      n_cmp++; if (ifc.retire_tag !== 7'd0) begin n_bad++; $display("FAIL ovf_hold_tag got %0d want 0", ifc.retire_tag); end
      log_tag.delete();
      log_pc.delete();
      log_cyc.delete();
      // Tag 8 pushes on the same edge the single ready pulse pops tag 0.
      cycle(1'b1, 16'h0500, 16'h5000, 1'b0, 1'b0, 1'b0);
      idle(4, 1'b0);
      cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
      n_cmp++; if (drop_cnt !== 8'd4) begin n_bad++; $display("FAIL ovf_pushpop_drop got %0d want 4", drop_cnt); end
      n_cmp++; if (ifc.retire_tag !== 7'd1) begin n_bad++; $display("FAIL ovf_pushpop_head got %0d want 1", ifc.retire_tag); end
      idle(6, 1'b1);
      n_cmp++; if (log_tag.size() != 5) begin n_bad++; $display("FAIL ovf_drain_count got %0d want 5", log_tag.size()); end
      for (int i = 0; i < 5 && i < log_tag.size(); i++) begin
         n_cmp++; if (log_tag[i] !== exp_t[i]) begin n_bad++; $display("FAIL ovf_drain_tag[%0d] got %0d want %0d", i, log_tag[i], exp_t[i]); end
      end
      n_cmp++; if (ifc.retire_valid !== 1'b0) begin n_bad++; $display("FAIL ovf_drained_valid got %0b want 0", ifc.retire_valid); end
      n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky got %0b want 1", overflow); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int k = 0; k < 7; k++) cycle(1'b1, 16'(16'h0600 + 2 * k), 16'(16'h6000 + k), 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
      n_cmp++; if (ifc.retire_tag !== 7'd0 || ifc.retire_valid !== 1'b1) begin n_bad++; $display("FAIL mid_queued got valid=%0b tag=%0d want valid=1 tag=0", ifc.retire_valid, ifc.retire_tag); end
      rst = 1'b1;
      cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
      n_cmp++; if (ifc.retire_valid !== 1'b0) begin n_bad++; $display("FAIL mid_valid got %0b want 0", ifc.retire_valid); end
      n_cmp++; if (ifc.retire_tag !== 7'd0) begin n_bad++; $display("FAIL mid_tag got %0d want 0", ifc.retire_tag); end
      rst = 1'b0;
      idle(8, 1'b1);
      n_cmp++; if (log_tag.size() != 0) begin n_bad++; $display("FAIL mid_stale_records got %0d want 0", log_tag.size()); end
      cycle(1'b1, 16'h0700, 16'h7000, 1'b0, 1'b0, 1'b1);
      idle(8, 1'b1);
      n_cmp++; if (log_tag.size() != 1) begin n_bad++; $display("FAIL mid_new_count got %0d want 1", log_tag.size()); end
      if (log_tag.size() == 1) begin
         n_cmp++; if (log_tag[0] !== 7'd0) begin n_bad++; $display("FAIL mid_new_tag got %0d want 0", log_tag[0]); end
         n_cmp++; if (log_pc[0] !== 16'h0700) begin n_bad++; $display("FAIL mid_new_pc got %h want 0700", log_pc[0]); end
      end
   endtask

   initial begin
      rst              = 1'b1;
      ifc.stall        = 1'b0;
      ifc.flush        = 1'b0;
      ifc.fetch_valid  = 1'b0;
      ifc.fetch_pc     = 16'h0;
      ifc.fetch_instr  = 16'h0;
      ifc.retire_ready = 1'b0;
      @(negedge clk);
      test_reset();
      test_basic();
      test_stall();
      test_flush();
      test_wrap();
      test_overflow();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1);
   end
endmodule

// File: doc/pipeline_trace_gen.md
PIPELINE_TRACE_GEN -- requirements
Module: pipeline_trace_gen

Interface
REQ-001 SHALL have parameter TAG_MAX, default 71; the highest instruction tag value before wrap to 0.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4; the number of entries in the retire-record FIFO (power of 2).
REQ-003 SHALL have port clk, input, 1 bit; the single clock, with all state updating on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit; the reset, synchronous and active-high.
REQ-005 SHALL have port stall, input, 1 bit; CPU load-use stall that holds IF and ID and inserts a bubble into EX.
REQ-006 SHALL have port flush, input, 1 bit; taken-branch squash of the instruction currently in IF.
REQ-007 SHALL have port fetch_valid, input, 1 bit; fetch_pc/fetch_instr hold a real fetched instruction this cycle.
REQ-008 SHALL have port fetch_pc, input, 16 bits; PC of the fetched instruction.
REQ-009 SHALL have port fetch_instr, input, 16 bits; encoding of the fetched instruction.
REQ-010 SHALL have port retire_valid, output, 1 bit; the FIFO head holds a retire record.
REQ-011 SHALL have port retire_ready, input, 1 bit; the consumer accepts the head record this cycle.
REQ-012 SHALL have port retire_tag, output, 7 bits; tag of the head record.
REQ-013 SHALL have port retire_pc, output, 16 bits; PC of the head record.
REQ-014 SHALL have port retire_instr, output, 16 bits; instruction encoding of the head record.
REQ-015 SHALL have port overflow, output, 1 bit; sticky flag set when a retire record was dropped.
REQ-016 SHALL have port drop_cnt, output, 8 bits; saturating count of dropped records.

Function
REQ-017 SHALL keep five slots IF, ID, EX, MEM, WB, each holding {valid, tag, pc, instr}.
REQ-018 SHALL, when stall=0, load IF with {fetch_valid, next_tag, fetch_pc, fetch_instr} and shift ID<=IF, EX<=ID, MEM<=EX, WB<=MEM.
REQ-019 SHALL advance next_tag only when stall=0 and fetch_valid=1, wrapping TAG_MAX->0 (71->0).
REQ-020 SHALL, when stall=1, hold IF, ID and next_tag, load EX with valid=0, and shift MEM<=EX and WB<=MEM.
REQ-021 SHALL, when flush=1 and stall=0, load ID with valid=0 (squash IF) while IF loads the new fetch normally; the squashed tag is consumed and not reused.
REQ-022 SHALL give stall priority when stall and flush are both 1, ignoring flush that cycle.
REQ-023 SHALL push {WB.tag, WB.pc, WB.instr} into the FIFO on each rising edge where WB.valid=1, giving a one-cycle latency from WB occupancy to FIFO visibility.
REQ-024 SHALL pop the FIFO on retire_valid & retire_ready; retire_* outputs come from registered FIFO storage and are stable while retire_valid=1 and retire_ready=0.
REQ-025 SHALL, on push when FIFO full with no pop, drop the record, set overflow=1, and increment drop_cnt saturating at 255.
REQ-026 SHALL, on push and pop in the same cycle with FIFO full, complete both with no drop.
REQ-027 SHALL, on pop when empty, have no effect, since retire_valid is 0 in that case.
REQ-028 SHALL emit retired tags in strictly increasing order mod (TAG_MAX+1), with gaps only for squashed instructions.

Reset
REQ-029 SHALL, with rst=1, clear all slot valids, set next_tag=0, empty the FIFO, and drive retire_valid=0, retire_tag/pc/instr=0, overflow=0, drop_cnt=0 on the next edge.
REQ-030 SHALL, on rst asserted mid-operation, discard in-flight and queued records, and SHALL NOT deliver any record after reset deasserts until a new fetch reaches WB.
REQ-031 SHALL, on the first fetch after reset, assign tag 0.

Structure
REQ-032 SHALL place the stage-slot record typedef (valid, tag, pc, instr), the retire record typedef and TAG_W=7 in the shared Monitor_tasks package.
REQ-033 SHALL implement the FIFO as one sub-module, trace_fifo (parameterized width/depth, valid/ready out, full/empty).

Verification
REQ-034 SHALL cover: reset, then 6 consecutive fetches (pc 0x0000..0x000A) with no stall -> retire tags 0..5 appear on retire_valid starting 5 cycles after the first fetch, with retire_ready=1.
REQ-035 SHALL cover: stall for 1 cycle while tag 2 is in ID -> EX gets a bubble, tag 2 retires one cycle later than unstalled, with no gap in the tag sequence.
REQ-036 SHALL cover: flush while tag 4 is in IF -> tag 4 never retires; the retire sequence reads 3, 5, 6.
REQ-037 SHALL cover: 80 fetches, no stall -> tags wrap 71 -> 0 and 72 records are followed by tags 0..7.
REQ-038 SHALL cover: retire_ready=0 for 8 retiring instructions with depth 4 -> 4 records held, overflow=1, drop_cnt=4; a full FIFO with simultaneous push and pop -> drop_cnt unchanged.
REQ-039 SHALL cover: rst asserted with 3 records queued and 4 slots valid -> retire_valid=0 next cycle, and the next retired tag is 0.
